// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// opcode constants, state encodings, control field codes and the
// control-word bundle passed from the output decoder to the top.
package multicycle_control_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_R_FORMAT = 6'h00;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_J        = 6'h02;

  // ALU B input select
  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Sequencer states; encodings are fixed so traces stay comparable
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9
  } state_t;

  // Datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write_enable;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Load or store: both go through the address-computation phase
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Moore output decoder: maps the sequencer state (plus mem_ready for
// the fetch commit) to the datapath control word. Purely combinational.
// Optional feature macro: MULTICYCLE_JUMP_EN (builds the JUMP outputs).
module multicycle_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  // Control word per state; everything not named for a state stays 0
  always_comb begin
    o_ctrl           = '0;
    o_ctrl.alu_src_b = ALU_B_RT;
    o_ctrl.alu_op    = ALU_OP_ADD;
    o_ctrl.pc_source = PC_SRC_ALU;
    case (i_state)
      ST_FETCH: begin
        // PC and IR commit only in the cycle the memory returns data
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ALU_B_FOUR;
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      ST_DECODE: begin
        // Speculative branch target into ALUOut
        o_ctrl.alu_src_b = ALU_B_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALU_B_IMM;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write_enable = 1'b1;
        o_ctrl.mem_to_reg       = 1'b1;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_write_enable = 1'b1;
        o_ctrl.reg_dst          = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_OP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PC_SRC_ALUOUT;
      end
`ifdef MULTICYCLE_JUMP_EN
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_SRC_JUMP;
      end
`endif
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: state register, next-state logic,
// illegal-opcode pulse and retired-instruction counter. Control outputs
// come from multicycle_output_decode and are forced to 0 during reset.
// Optional feature macro: MULTICYCLE_JUMP_EN (J opcode and JUMP state).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       operation,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write_enable,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_illegal;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;

  multicycle_output_decode u_output_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, illegal-opcode detection and retire strobe
  always_comb begin
    w_next_state = r_state;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_mem_op(operation)) begin
          w_next_state = ST_MEM_ADDR;
        end else if (operation == OP_R_FORMAT) begin
          w_next_state = ST_EXECUTE;
        end else if (operation == OP_BEQ) begin
          w_next_state = ST_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
        end else if (operation == OP_J) begin
          w_next_state = ST_JUMP;
`endif
        end else begin
          // Unsupported opcode: drop it without counting it as retired
          w_next_state = ST_FETCH;
          w_illegal    = 1'b1;
        end
      end
      ST_MEM_ADDR: begin
        if (operation == OP_LW) begin
          w_next_state = ST_MEM_READ;
        end else if (operation == OP_SW) begin
          w_next_state = ST_MEM_WRITE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_MEM_READ: begin
        if (mem_ready) begin
          w_next_state = ST_MEM_WB;
        end else begin
          w_next_state = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_MEM_WRITE: begin
        if (mem_ready) begin
          w_next_state = ST_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = ST_MEM_WRITE;
        end
      end
      ST_EXECUTE: begin
        w_next_state = ST_R_WB;
      end
      ST_R_WB: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_BRANCH: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      ST_JUMP: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
`endif
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end else begin
      r_retired <= r_retired;
    end
  end

  // Drive outputs; reset forces every control and the count to 0
  always_comb begin
    if (reset) begin
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      mem_to_reg       = 1'b0;
      reg_dst          = 1'b0;
      reg_write_enable = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      alu_op           = 2'b00;
      pc_source        = 2'b00;
      illegal_op       = 1'b0;
      retired          = '0;
    end else begin
      pc_write         = w_ctrl.pc_write;
      pc_write_cond    = w_ctrl.pc_write_cond;
      i_or_d           = w_ctrl.i_or_d;
      mem_read         = w_ctrl.mem_read;
      mem_write        = w_ctrl.mem_write;
      ir_write         = w_ctrl.ir_write;
      mem_to_reg       = w_ctrl.mem_to_reg;
      reg_dst          = w_ctrl.reg_dst;
      reg_write_enable = w_ctrl.reg_write_enable;
      alu_src_a        = w_ctrl.alu_src_a;
      alu_src_b        = w_ctrl.alu_src_b;
      alu_op           = w_ctrl.alu_op;
      pc_source        = w_ctrl.pc_source;
      illegal_op       = w_illegal;
      retired          = r_retired;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is
// expanded into its expected per-cycle control words from the phase
// tables; a compare process checks every cycle on the falling edge.
// Honours MULTICYCLE_JUMP_EN the same way the design does.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  operation = 6'h3F;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write_enable, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_cyc = 0;
  int          model_ret = 0;
  logic        exp_valid = 1'b0;
  logic [16:0] exp_ctrl = 17'd0;
  logic [31:0] exp_ret = 32'd0;
  logic [16:0] got_ctrl;

  multicycle_control #(.CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .operation        (operation),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .i_or_d           (i_or_d),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .ir_write         (ir_write),
    .mem_to_reg       (mem_to_reg),
    .reg_dst          (reg_dst),
    .reg_write_enable (reg_write_enable),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .alu_op           (alu_op),
    .pc_source        (pc_source),
    .illegal_op       (illegal_op),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  assign got_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write_enable, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op};

  // Control word layout: pcw pwc iord mr mw irw m2r rdst rwe asa asb aop psrc ill
  function automatic logic [16:0] ctl(input logic pcw, input logic pwc, input logic iord,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic m2r, input logic rdst, input logic rwe,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] psrc,
                                      input logic ill);
    return {pcw, pwc, iord, mr, mw, irw, m2r, rdst, rwe, asa, asb, aop, psrc, ill};
  endfunction

  // Per-phase expected control words
  function automatic logic [16:0] w_fetch(input logic rdy);
    return ctl(rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] w_decode(input logic ill);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, ill);
  endfunction
  localparam logic [16:0] W_ZERO     = 17'd0;
  localparam logic [16:0] W_MEM_ADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] W_MEM_READ = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_MEM_WB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] W_MEM_WR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_EXECUTE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] W_R_WB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] W_BRANCH   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] W_JUMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

  // Per-cycle compare against the model's expectation
  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp = n_cmp + 1;
      if (got_ctrl !== exp_ctrl) begin
        n_bad = n_bad + 1;
        $display("FAIL ctrl cycle %0d: got %b want %b", n_cyc, got_ctrl, exp_ctrl);
      end
      n_cmp = n_cmp + 1;
      if (retired !== exp_ret) begin
        n_bad = n_bad + 1;
        $display("FAIL retired cycle %0d: got %0d want %0d", n_cyc, retired, exp_ret);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock cycle: apply inputs and the expected outputs for it
  task automatic step(input logic [16:0] w, input logic rdy, input logic [5:0] op,
                      input logic rst);
    reset     = rst;
    mem_ready = rdy;
    operation = op;
    exp_ctrl  = w;
    exp_ret   = 32'(model_ret);
    exp_valid = 1'b1;
    n_cyc     = n_cyc + 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal(input logic [5:0] op);
`ifdef MULTICYCLE_JUMP_EN
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
`else
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04;
`endif
  endfunction

  // Whole instruction with optional fetch and data-memory stalls
  task automatic instr(input logic [5:0] op, input int fstall, input int mstall,
                       output int ncyc);
    int start;
    start = n_cyc;
    for (int i = 0; i < fstall; i++) step(w_fetch(1'b0), 1'b0, 6'h3F, 1'b0);
    step(w_fetch(1'b1), 1'b1, 6'h3F, 1'b0);
    // mem_ready deliberately low in non-memory phases
    step(w_decode(!legal(op)), 1'b0, op, 1'b0);
    if (legal(op)) begin
      case (op)
        6'h23: begin
          step(W_MEM_ADDR, 1'b0, op, 1'b0);
          for (int i = 0; i < mstall; i++) step(W_MEM_READ, 1'b0, op, 1'b0);
          step(W_MEM_READ, 1'b1, op, 1'b0);
          step(W_MEM_WB, 1'b0, op, 1'b0);
        end
        6'h2B: begin
          step(W_MEM_ADDR, 1'b0, op, 1'b0);
          for (int i = 0; i < mstall; i++) step(W_MEM_WR, 1'b0, op, 1'b0);
          step(W_MEM_WR, 1'b1, op, 1'b0);
        end
        6'h00: begin
          step(W_EXECUTE, 1'b0, op, 1'b0);
          step(W_R_WB, 1'b0, op, 1'b0);
        end
        6'h04: step(W_BRANCH, 1'b0, op, 1'b0);
        default: step(W_JUMP, 1'b0, op, 1'b0);
      endcase
      model_ret = model_ret + 1;
    end
    ncyc = n_cyc - start;
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    // Reset held 3 cycles with mem_ready high: everything 0
    model_ret = 0;
    for (int i = 0; i < 3; i++) step(W_ZERO, 1'b1, 6'h23, 1'b1);

    instr(6'h23, 0, 2, n);
    chk("lw_stall_cycles", n, 7);
    chk("lw_retired", int'(retired), 1);

    instr(6'h00, 0, 0, n);
    chk("rformat_cycles", n, 4);
    instr(6'h2B, 0, 0, n);
    chk("sw_cycles", n, 4);
    instr(6'h04, 0, 0, n);
    chk("beq_cycles", n, 3);
    chk("retired_after_mix", int'(retired), 4);

    instr(6'h3F, 0, 0, n);
    chk("illegal_cycles", n, 2);
    chk("retired_after_illegal", int'(retired), 4);

    instr(6'h02, 0, 0, n);
`ifdef MULTICYCLE_JUMP_EN
    chk("j_cycles", n, 3);
    chk("retired_after_j", int'(retired), 5);
`else
    chk("j_cycles", n, 2);
    chk("retired_after_j", int'(retired), 4);
`endif

    instr(6'h04, 2, 0, n);
    chk("beq_fetch_stall_cycles", n, 5);
    instr(6'h2B, 1, 3, n);
    chk("sw_both_stall_cycles", n, 8);
    instr(6'h08, 0, 0, n);
    chk("illegal_addi_cycles", n, 2);

    // Reset during a stalled store: write drops immediately, count clears
    step(w_fetch(1'b1), 1'b1, 6'h3F, 1'b0);
    step(w_decode(1'b0), 1'b0, 6'h2B, 1'b0);
    step(W_MEM_ADDR, 1'b0, 6'h2B, 1'b0);
    step(W_MEM_WR, 1'b0, 6'h2B, 1'b0);
    model_ret = 0;
    step(W_ZERO, 1'b0, 6'h2B, 1'b1);
    instr(6'h00, 0, 0, n);
    chk("rformat_after_reset_cycles", n, 4);
    chk("retired_after_reset", int'(retired), 1);

    exp_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
